// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the PC/fetch block: datapath width, fetch FSM state
// encodings and the default reset PC.
package pc_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        FETCH_S_REQ  = 2'd0,
        FETCH_S_WAIT = 2'd1,
        FETCH_S_HOLD = 2'd2,
        FETCH_S_ERR  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_wrap_counter.sv
// Free-running up counter with enable; wraps modulo 2^W.
module wrap_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC owner: fetches the word at pc over req/gnt/rvalid and
// presents {pc, instr} downstream; loads npc when downstream accepts.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  npc,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  instr,
    output logic             fetch_err,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_d;
    logic            err_q;
    logic            err_d;
    logic            accept;
    logic            misaligned;

    assign misaligned = (pc_q[1:0] != 2'b00);

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        err_d   = err_q;
        accept  = 1'b0;
        unique case (state_q)
            FETCH_S_REQ: begin
                if (misaligned) begin
                    state_d = FETCH_S_ERR;
                    err_d   = 1'b1;
                end else if (imem_gnt) begin
                    state_d = FETCH_S_WAIT;
                end
            end
            FETCH_S_WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = FETCH_S_HOLD;
                end
            end
            FETCH_S_HOLD: begin
                if (instr_ready) begin
                    pc_d    = npc;
                    accept  = 1'b1;
                    state_d = FETCH_S_REQ;
                end
            end
            FETCH_S_ERR: begin
                state_d = FETCH_S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    wrap_counter #(
        .W (CNT_W)
    ) u_fetch_count (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .count (fetch_count)
    );

    // Handshake strobes are state decodes, forced low while reset is applied
    assign imem_req    = !rst && (state_q == FETCH_S_REQ) && !misaligned;
    assign instr_valid = !rst && (state_q == FETCH_S_HOLD);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign fetch_err   = err_q;

endmodule
